// File: rtl/clock_gen_irq_mc.sv
// clock_gen_irq_mc: multi-channel programmable tick / divided-clock generator
// with a small register file, shadowed dividers, one-shot mode and a maskable
// interrupt that is either level (registered GIE & |IPR) or a one-cycle pulse.
module clock_gen_irq_mc #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 16,
    parameter int IRQ_LEVEL = 1
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              reg_wr_en,
    input  logic              reg_rd_en,
    input  logic [7:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              reg_rvalid,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic              irq
);

    // Word offsets (reg_addr[7:2]) of the control registers.
    localparam logic [5:0] A_GIE  = 6'h00;
    localparam logic [5:0] A_IER  = 6'h01;
    localparam logic [5:0] A_ISR  = 6'h02;
    localparam logic [5:0] A_IAR  = 6'h03;
    localparam logic [5:0] A_IPR  = 6'h04;
    localparam logic [5:0] A_RUN  = 6'h05;
    localparam logic [5:0] A_MODE = 6'h06;
    localparam logic [5:0] A_DIV0 = 6'h08;

    logic [5:0]        word;
    logic              unused_bits;

    logic              gie;
    logic [NUM_CH-1:0] ier;
    logic [NUM_CH-1:0] isr;
    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] mode;
    logic [DIV_W-1:0]  div [NUM_CH];
    logic [DIV_W-1:0]  act [NUM_CH];
    logic [DIV_W-1:0]  cnt [NUM_CH];

    logic [NUM_CH-1:0] ipr;
    logic [NUM_CH-1:0] tc;
    logic [NUM_CH-1:0] div_sel;
    logic [NUM_CH-1:0] div_we;
    logic              wr_gie;
    logic              wr_ier;
    logic              wr_iar;
    logic              wr_run;
    logic              wr_mode;
    logic [NUM_CH-1:0] run_nxt;
    logic [NUM_CH-1:0] isr_clr;
    logic [NUM_CH-1:0] isr_nxt;
    logic [31:0]       rd_mux;

    // Byte address bits [1:0] are don't-care; upper write-data bits beyond
    // the widest field are simply not stored.
    assign word        = reg_addr[7:2];
    assign unused_bits = ^{reg_addr[1:0], reg_wdata};
    assign ipr         = isr & ier;

    // Register write decode, including the per-channel divider slots.
    always_comb begin
        wr_gie  = reg_wr_en && (word == A_GIE);
        wr_ier  = reg_wr_en && (word == A_IER);
        wr_iar  = reg_wr_en && (word == A_IAR);
        wr_run  = reg_wr_en && (word == A_RUN);
        wr_mode = reg_wr_en && (word == A_MODE);
        div_sel = '0;
        div_we  = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            div_sel[n] = (word == A_DIV0 + 6'(n));
            div_we[n]  = reg_wr_en && div_sel[n];
        end
    end

    // Terminal count: running channel with a nonzero divider at its limit.
    always_comb begin
        tc = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            tc[n] = run[n] && (act[n] != '0) && (cnt[n] == act[n]);
        end
    end

    // Next RUN: one-shot auto-clear, overridden by a RUN write in the same cycle.
    always_comb begin
        run_nxt = run;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (tc[n] && mode[n]) begin
                run_nxt[n] = 1'b0;
            end
        end
        if (wr_run) begin
            run_nxt = reg_wdata[NUM_CH-1:0];
        end
    end

    // Next ISR: write-1-to-clear, with a same-cycle set taking priority.
    always_comb begin
        isr_clr = wr_iar ? reg_wdata[NUM_CH-1:0] : '0;
        isr_nxt = (isr & ~isr_clr) | tc;
    end

    // Control registers and divider shadows.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            gie  <= 1'b0;
            ier  <= '0;
            isr  <= '0;
            run  <= '0;
            mode <= '0;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                div[n] <= '0;
            end
        end else begin
            if (wr_gie) begin
                gie <= reg_wdata[0];
            end
            if (wr_ier) begin
                ier <= reg_wdata[NUM_CH-1:0];
            end
            if (wr_mode) begin
                mode <= reg_wdata[NUM_CH-1:0];
            end
            run <= run_nxt;
            isr <= isr_nxt;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (div_we[n]) begin
                    div[n] <= reg_wdata[DIV_W-1:0];
                end
            end
        end
    end

    // Per-channel counters: ACT follows DIV while stopped and is re-armed
    // only at terminal count, so a divider write never cuts a period short.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            tick    <= '0;
            clk_out <= '0;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                cnt[n] <= '0;
                act[n] <= '0;
            end
        end else begin
            tick <= tc;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (!run[n]) begin
                    cnt[n] <= '0;
                    act[n] <= div[n];
                end else if (tc[n]) begin
                    cnt[n]     <= '0;
                    act[n]     <= div[n];
                    clk_out[n] <= ~clk_out[n];
                end else if (act[n] != '0) begin
                    cnt[n] <= cnt[n] + DIV_W'(1);
                end
            end
        end
    end

    // Read mux; unmapped words (including DIV slots past NUM_CH) read 0.
    always_comb begin
        rd_mux = '0;
        case (word)
            A_GIE:   rd_mux[0]          = gie;
            A_IER:   rd_mux[NUM_CH-1:0] = ier;
            A_ISR:   rd_mux[NUM_CH-1:0] = isr;
            A_IPR:   rd_mux[NUM_CH-1:0] = ipr;
            A_RUN:   rd_mux[NUM_CH-1:0] = run;
            A_MODE:  rd_mux[NUM_CH-1:0] = mode;
            default: rd_mux = '0;
        endcase
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (div_sel[n]) begin
                rd_mux[DIV_W-1:0] = div[n];
            end
        end
    end

    // Registered read port: data samples pre-write state, valid for one cycle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
        end else begin
            reg_rvalid <= reg_rd_en;
            if (reg_rd_en) begin
                reg_rdata <= rd_mux;
            end
        end
    end

    generate
        if (IRQ_LEVEL != 0) begin : g_level
            // Level interrupt: registered copy of GIE & |IPR.
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    irq <= 1'b0;
                end else begin
                    irq <= gie & (|ipr);
                end
            end
        end else begin : g_pulse
            logic [NUM_CH-1:0] ipr_prev;
            // Pulse interrupt: rising edge of any IPR bit while GIE is set;
            // ipr_prev tracks IPR independently of GIE so enabling GIE late
            // never fires for bits that were already pending.
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    irq      <= 1'b0;
                    ipr_prev <= '0;
                end else begin
                    irq      <= gie & (|(ipr & ~ipr_prev));
                    ipr_prev <= ipr;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_clock_gen_irq_mc.sv
// Testbench for clock_gen_irq_mc: a level-IRQ and a pulse-IRQ instance share
// stimulus; a countdown reference model predicts ticks, clocks, IRQs and
// register contents, and a monitor compares every cycle and every read.
module tb_clock_gen_irq_mc;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;

    logic        ACLK   = 1'b0;
    logic        ARESET = 1'b0;
    logic        wr_en  = 1'b0;
    logic        rd_en  = 1'b0;
    logic [7:0]  addr   = '0;
    logic [31:0] wdata  = '0;

    logic [31:0]       rdata, rdata_p;
    logic              rvalid, rvalid_p;
    logic [NUM_CH-1:0] tick, tick_p, clk_out, clk_out_p;
    logic              irq, irq_p;

    always #5 ACLK = ~ACLK;

    clock_gen_irq_mc #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .IRQ_LEVEL(1)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .reg_wr_en(wr_en), .reg_rd_en(rd_en),
        .reg_addr(addr), .reg_wdata(wdata), .reg_rdata(rdata), .reg_rvalid(rvalid),
        .tick(tick), .clk_out(clk_out), .irq(irq)
    );

    clock_gen_irq_mc #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .IRQ_LEVEL(0)) dut_p (
        .ACLK(ACLK), .ARESET(ARESET), .reg_wr_en(wr_en), .reg_rd_en(rd_en),
        .reg_addr(addr), .reg_wdata(wdata), .reg_rdata(rdata_p), .reg_rvalid(rvalid_p),
        .tick(tick_p), .clk_out(clk_out_p), .irq(irq_p)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_exp_t;
    rd_exp_t rq[$];

    // Reference model: each running channel counts down the cycles left
    // until its next tick; ACT is the period length in force.
    logic              m_gie;
    logic [NUM_CH-1:0] m_ier, m_isr, m_run, m_mode, m_tick, m_clk, m_last_ipr;
    logic              m_irq, m_irq_p;
    int                m_div  [NUM_CH];
    int                m_act  [NUM_CH];
    int                m_left [NUM_CH];

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, want, $time);
        end
    endfunction

    task automatic model_reset();
        m_gie = 1'b0; m_ier = '0; m_isr = '0; m_run = '0; m_mode = '0;
        m_tick = '0; m_clk = '0; m_last_ipr = '0; m_irq = 1'b0; m_irq_p = 1'b0;
        for (int n = 0; n < NUM_CH; n++) begin
            m_div[n] = 0; m_act[n] = 0; m_left[n] = 0;
        end
    endtask

    task automatic model_update();
        logic [NUM_CH-1:0] tc, ipr, clr;
        int w;
        tc  = '0;
        ipr = m_isr & m_ier;
        w   = int'(addr[7:2]);
        m_irq      = m_gie && (ipr != 0);
        m_irq_p    = m_gie && ((ipr & ~m_last_ipr) != 0);
        m_last_ipr = ipr;
        for (int n = 0; n < NUM_CH; n++) begin
            if (m_run[n] && m_act[n] != 0) begin
                if (m_left[n] == 1) tc[n] = 1'b1;
                else m_left[n]--;
            end
            if (!m_run[n] || tc[n]) begin
                m_act[n]  = m_div[n];
                m_left[n] = m_div[n] + 1;
            end
            if (tc[n]) m_clk[n] = ~m_clk[n];
            if (tc[n] && m_mode[n]) m_run[n] = 1'b0;
        end
        m_tick = tc;
        clr    = (wr_en && w == 3) ? wdata[NUM_CH-1:0] : '0;
        m_isr  = (m_isr & ~clr) | tc;
        if (wr_en) begin
            case (w)
                0:         m_gie  = wdata[0];
                1:         m_ier  = wdata[NUM_CH-1:0];
                5:         m_run  = wdata[NUM_CH-1:0];
                6:         m_mode = wdata[NUM_CH-1:0];
                8, 9, 10, 11: m_div[w-8] = int'(wdata[DIV_W-1:0]);
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] exp_read(logic [7:0] a);
        int w;
        w = int'(a[7:2]);
        case (w)
            0:            return {31'b0, m_gie};
            1:            return 32'(m_ier);
            2:            return 32'(m_isr);
            4:            return 32'(m_isr & m_ier);
            5:            return 32'(m_run);
            6:            return 32'(m_mode);
            8, 9, 10, 11: return 32'(m_div[w-8]);
            default:      return 32'h0;
        endcase
    endfunction

    // One clock: model advances on the edge, control returns at the negedge.
    task automatic step();
        @(posedge ACLK);
        if (ARESET) model_reset();
        else model_update();
        @(negedge ACLK);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_read(logic [7:0] a);
        rd_exp_t e;
        e.data = exp_read(a);
        e.due  = cyc + 1;
        rq.push_back(e);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        rd_en = 1'b1; addr = a;
        push_read(a);
        step();
        rd_en = 1'b0;
    endtask

    task automatic rdwr(input logic [7:0] a, input logic [31:0] d);
        rd_en = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
        push_read(a);
        step();
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic read_all();
        logic [7:0] tab [13];
        tab = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                8'h20, 8'h24, 8'h28, 8'h2C, 8'h30};
        for (int i = 0; i < 13; i++) rd(tab[i]);
    endtask

    // Advance until the model says channel ch reaches terminal count on the next edge.
    task automatic wait_tc(int ch);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_run[ch] && m_act[ch] != 0 && m_left[ch] == 1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("wait_tc", 32'(found), 32'h1);
    endtask

    task automatic check_outputs_zero();
        check("rst_tick",     32'(tick),      32'h0);
        check("rst_clk_out",  32'(clk_out),   32'h0);
        check("rst_irq",      32'(irq),       32'h0);
        check("rst_rvalid",   32'(rvalid),    32'h0);
        check("rst_rdata",    rdata,          32'h0);
        check("rst_tick_p",   32'(tick_p),    32'h0);
        check("rst_clk_p",    32'(clk_out_p), 32'h0);
        check("rst_irq_p",    32'(irq_p),     32'h0);
        check("rst_rvalid_p", 32'(rvalid_p),  32'h0);
        check("rst_rdata_p",  rdata_p,        32'h0);
    endtask

    always @(posedge ACLK) cyc <= cyc + 1;

    // Monitor: per-cycle output comparison and read-data scoreboard.
    always @(negedge ACLK) begin
        rd_exp_t e;
        check("tick",      32'(tick),      32'(m_tick));
        check("clk_out",   32'(clk_out),   32'(m_clk));
        check("irq_level", 32'(irq),       32'(m_irq));
        check("tick_p",    32'(tick_p),    32'(m_tick));
        check("clk_out_p", 32'(clk_out_p), 32'(m_clk));
        check("irq_pulse", 32'(irq_p),     32'(m_irq_p));
        if (rq.size() != 0 && rq[0].due <= cyc) begin
            e = rq.pop_front();
            check("rvalid",   32'(rvalid),   32'h1);
            check("rdata",    rdata,         e.data);
            check("rvalid_p", 32'(rvalid_p), 32'h1);
            check("rdata_p",  rdata_p,       e.data);
        end else begin
            check("rvalid_idle",   32'(rvalid),   32'h0);
            check("rvalid_idle_p", 32'(rvalid_p), 32'h0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rtab [14];
        logic [7:0] a;
        logic [31:0] d;
        int r;
        rtab = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                 8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'hFC};

        model_reset();
        #1 ARESET = 1'b1;
        #1 check_outputs_zero();
        idle(2);
        ARESET = 1'b0;
        read_all();

        // Basic tick path on channel 0.
        wr(8'h20, 32'd4);
        wr(8'h14, 32'h1);
        idle(25);
        rd(8'h08);

        // Level interrupt, then acknowledge.
        wr(8'h00, 32'h1);
        wr(8'h04, 32'h1);
        idle(8);
        wr(8'h14, 32'h0);
        idle(2);
        rd(8'h10);
        wr(8'h0C, 32'h1);
        rd(8'h10);
        idle(3);

        // Acknowledge coinciding with a tick: set wins.
        wr(8'h14, 32'h1);
        wait_tc(0);
        wr(8'h0C, 32'h1);
        rd(8'h08);

        // Divider shadow on channel 1.
        wr(8'h24, 32'd9);
        wr(8'h14, 32'h3);
        idle(4);
        wr(8'h24, 32'd2);
        idle(30);

        // One-shot on channel 2.
        wr(8'h18, 32'h4);
        wr(8'h28, 32'd3);
        wr(8'h14, 32'h4);
        idle(10);
        rd(8'h14);

        // RUN write coinciding with one-shot auto-clear.
        wr(8'h18, 32'hC);
        wr(8'h2C, 32'd2);
        wr(8'h14, 32'h8);
        wait_tc(3);
        wr(8'h14, 32'h8);
        idle(6);
        rd(8'h14);
        wr(8'h14, 32'h0);

        // Pulse IRQ via IER on pending ISR; no retroactive pulse on GIE enable.
        wr(8'h04, 32'h0);
        idle(2);
        wr(8'h04, 32'hF);
        idle(3);
        wr(8'h00, 32'h0);
        wr(8'h04, 32'h0);
        wr(8'h04, 32'hF);
        idle(2);
        wr(8'h00, 32'h1);
        idle(3);

        // Same-cycle read/write and unmapped space.
        rdwr(8'h18, 32'h5);
        rd(8'h18);
        rdwr(8'h20, 32'd7);
        rd(8'h1C);
        wr(8'h30, 32'h1234);
        wr(8'hFC, 32'hFFFF_FFFF);
        rd(8'h30);
        rd(8'hFC);
        rd(8'h23);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 9);
            a = rtab[$urandom_range(0, 13)] | 8'($urandom_range(0, 3));
            d = (a[7:2] >= 6'd8) ? 32'($urandom_range(0, 12)) : $urandom;
            if (r <= 3) idle(1);
            else if (r <= 5) rd(a);
            else if (r <= 8) wr(a, d);
            else rdwr(a, d);
        end

        // Reset in the middle of running periods.
        wr(8'h20, 32'd3);
        wr(8'h24, 32'd5);
        wr(8'h14, 32'hF);
        idle(7);
        #2;
        ARESET = 1'b1;
        model_reset();
        rq.delete();
        #1 check_outputs_zero();
        idle(2);
        ARESET = 1'b0;
        read_all();
        idle(12);

        idle(4);
        check("rd_queue_drained", 32'(rq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_gen_irq_mc.md
CLOCK_GEN_IRQ_MC -- requirements
Module: clock_gen_irq_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independent tick/clock channels (legal 1..16).
REQ-002 SHALL have parameter DIV_W, default 16, meaning the divider width in bits (legal 2..32).
REQ-003 SHALL have parameter IRQ_LEVEL, default 1, meaning 1 = level interrupt and 0 = one-cycle pulse interrupt.
REQ-004 SHALL have the following ports:
- ACLK  in  1  sole clock.
- ARESET  in  1  asynchronous, active-high reset.
- reg_wr_en  in  1  register write strobe.
- reg_rd_en  in  1  register read strobe.
- reg_addr  in  8  byte address; bits [1:0] are ignored.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data.
- reg_rvalid  out  1  read data valid.
- tick  out  NUM_CH  per-channel one-cycle terminal-count pulse.
- clk_out  out  NUM_CH  per-channel divided square wave.
- irq  out  1  active-high interrupt.

Function
REQ-005 SHALL implement this register map:
- 0x00 GIE: bit0 is the global interrupt enable.
- 0x04 IER: bits [NUM_CH-1:0] are the per-channel interrupt enables.
- 0x08 ISR: raw status, read-only.
- 0x0C IAR: write-1-to-clear for ISR; reads return 0.
- 0x10 IPR: ISR & IER, read-only.
- 0x14 RUN: bits [NUM_CH-1:0] are the run enables.
- 0x18 MODE: bits [NUM_CH-1:0], where 1 = one-shot.
- 0x20+4n DIV[n]: shadow divider for channel n, low DIV_W bits.
REQ-006 SHALL make reg_rdata and reg_rvalid valid exactly 1 cycle after reg_rd_en; reg_rvalid SHALL be high for 1 cycle per read.
REQ-007 SHALL return 0 on reads of unmapped addresses, including DIV slots n>=NUM_CH, and SHALL ignore writes to them.
REQ-008 SHALL make a read and a write in the same cycle to the same address return the pre-write value.
REQ-009 SHALL give each channel a DIV_W-bit counter that increments every cycle while RUN[n]=1 and the active divider ACT[n] is nonzero.
REQ-010 SHALL, when counter == ACT[n] with RUN[n]=1:
- assert tick[n] for the next cycle;
- clear the counter to 0;
- toggle clk_out[n].
The tick period is ACT[n]+1 cycles and the clk_out period is 2*(ACT[n]+1) cycles.
REQ-011 SHALL load ACT[n] from DIV[n] at each terminal count and on every cycle where RUN[n]=0, so a divider write never truncates a running period.
REQ-012 SHALL never tick a channel with ACT[n]=0; the counter holds 0 and clk_out holds its value.
REQ-013 SHALL, when RUN[n] is written 0, clear the counter to 0 on the next cycle and freeze clk_out[n] at its current level.
REQ-014 SHALL, in one-shot mode (MODE[n]=1), clear RUN[n] in the same cycle tick[n] is asserted.
REQ-015 SHALL let a RUN write in the same cycle as a one-shot auto-clear take precedence over the auto-clear.
REQ-016 SHALL set ISR[n] in the cycle tick[n] is asserted, regardless of IER and GIE.
REQ-017 SHALL clear ISR[n] only by an IAR write with bit n=1.
REQ-018 SHALL keep ISR[n] set when a set and a clear of bit n occur in the same cycle (set wins).
REQ-019 SHALL, with IRQ_LEVEL=1, drive irq as a register equal to GIE & |IPR, lagging 1 cycle.
REQ-020 SHALL, with IRQ_LEVEL=0, pulse irq for 1 cycle whenever GIE=1 and any IPR bit transitions 0->1, including by IER being written on an already-set ISR bit.
REQ-021 SHALL produce no retroactive irq pulse when GIE goes 0->1 in IRQ_LEVEL=0 mode.
REQ-022 SHALL keep the maximum counter value 2^DIV_W-1 legal, with no overflow past ACT.

Reset
REQ-023 SHALL, while ARESET=1, immediately force:
- GIE, IER, ISR, RUN, MODE, all DIV, all ACT and all counters to 0;
- tick, clk_out, irq, reg_rvalid and reg_rdata to 0.
REQ-024 SHALL, on deassertion of ARESET, begin operation on the first ACLK rising edge.
REQ-025 SHALL abort in-progress periods when reset is asserted mid-operation, with no tick emitted.

Verification
REQ-026 SHALL verify the basic tick path: DIV[0]=4, RUN=1 -> tick[0] every 5 cycles, clk_out[0] period 10, ISR=0x1 after the first tick.
REQ-027 SHALL verify the level interrupt: GIE=1, IER=1, tick on ch0 -> irq=1 one cycle after ISR sets; IPR reads 0x1; IAR=0x1 -> IPR reads 0x0 and irq=0 within 2 cycles.
REQ-028 SHALL verify the divider shadow: ch1 running with DIV=9; DIV[1]=2 is written mid-period -> the current period still completes at 10 cycles, and subsequent periods are 3 cycles.
REQ-029 SHALL verify one-shot mode: MODE=0x4, DIV[2]=3, RUN=0x4 -> exactly one tick[2] after 4 cycles, and RUN reads 0x0 afterward.
REQ-030 SHALL verify the simultaneous set/clear: an IAR clear of bit0 coincides with tick[0] -> ISR[0] remains 1.
REQ-031 SHALL verify reset mid-operation: ARESET pulsed mid-period -> all outputs are 0 immediately, and all registers read 0 after release.
